stream_mux_arb: RTL and testbench
=================================

// Module: stream_mux_arb
// PURPOSE
//  Parametrised N-to-1 registered stream multiplexer with valid/ready handshake and packet lock.
//  Selects one of N_IN input channels by round-robin, fixed priority or external select.
//  Holds the selection until the packet's last beat has transferred.
//  Sits between multiple producers (e.g. writeback/forwarding sources, bus masters) and one consumer.
// PARAMETERS
//  WIDTH   32  data bits per channel
//  N_IN    4   number of input channels (>=1)
//  MODE    0   0 = round-robin, 1 = fixed priority (ch0 highest), 2 = external select (ext_sel)
//  SEL_W   $clog2(N_IN) (min 1)  width of channel index
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  in_data    in   N_IN*WIDTH   channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid   in   N_IN         per-channel beat valid
//  in_last    in   N_IN         per-channel last beat of packet
//  in_ready   out  N_IN         per-channel accept; at most one bit high
//  ext_sel    in   SEL_W        channel request in MODE 2; sampled only when unlocked
//  out_data   out  WIDTH        registered output data
//  out_valid  out  1            registered output valid
//  out_last   out  1            registered last flag
//  out_src    out  SEL_W        index of channel that produced current out beat
//  out_ready  in   1            consumer accept
//  busy       out  1            high while a packet is locked
// BEHAVIOUR
//  - Reset (async assert, sync-deasserted by system): out_valid=0, out_data=0, out_last=0, out_src=0.
//    busy=0, state=IDLE, rr_ptr=0, grant=0. in_ready=0 while rst_n low.
//  - Output slot: single register stage. can_load = !out_valid | out_ready.
//    Transfer in = in_valid[g] & in_ready[g]. Transfer out = out_valid & out_ready.
//    Latency: 1 cycle from input transfer to out_valid.
//    Full throughput, 1 beat/cycle, when out_ready is held high.
//  - While out_valid & !out_ready: out_data/out_last/out_src hold stable.
//  - in_ready[i] = can_load & (i == g) & (state==LOCKED | arbitration picked i this cycle). All other bits 0.
//  - FSM IDLE:
//    - Arbitrate combinationally among in_valid.
//      - MODE 0: first valid at or after rr_ptr, wrapping N_IN-1 -> 0.
//      - MODE 1: lowest valid index.
//      - MODE 2: g = ext_sel, only if in_valid[ext_sel]; ext_sel >= N_IN grants nothing.
//    - No valid request: stay IDLE, no transfer.
//    - If a request exists and can_load: transfer the beat.
//      - If in_last is set, stay IDLE (single-beat packet).
//      - Otherwise go LOCKED with grant=g, busy=1.
//    - If a request exists but !can_load: no grant is latched; re-arbitrate next cycle.
//  - FSM LOCKED: only grant channel is served; other valids and ext_sel are ignored.
//    - Transfer with in_last=1 -> IDLE, busy=0.
//    - in_valid[grant]=0 -> wait (bubble). No timeout.
//  - rr_ptr (MODE 0 only) <= (g+1) mod N_IN on every packet-ending transfer (last beat). Unchanged otherwise.
//  - Simultaneous in-transfer and out-transfer in the same cycle: register reloads, out_valid stays 1.
//  - Reset mid-packet: the locked packet is abandoned and the output beat is dropped. No recovery.
//  - N_IN=1: arbitration is trivial, SEL_W=1, out_src=0 always.
// STRUCTURE
//  - Shared package stream_pkg: MODE_RR/MODE_PRIO/MODE_EXT localparams, state encoding (IDLE=1'b0, LOCKED=1'b1).
//  - One sub-module: rr_arbiter #(N_IN) (req, ptr -> one-hot grant + index), combinational.
//    Reused for MODE 1 with ptr tied to 0.
//  - Datapath: priority-free indexed select in_data[g*WIDTH +: WIDTH] feeding the output register.
// TESTING
//  1. MODE 0, N_IN=4, all valid, single-beat packets, out_ready=1:
//     out_src sequence 0,1,2,3,0; one beat/cycle after 1-cycle latency.
//  2. MODE 0, ch1 sends 3-beat packet (last on beat 3) while ch2 valid:
//     out_src=1,1,1 then 2; in_ready[2]=0 until ch1 last transfers.
//  3. Backpressure: out_ready=0 for 3 cycles with out_valid=1, data=0xA5A5A5A5:
//     out_data stable, in_ready all 0; release -> next beat the following cycle.
//  4. MODE 1, ch3 and ch0 valid:
//     ch0 served first.
//  5. MODE 2:
//     ext_sel=2 with ch2 valid -> out_src=2.
//     ext_sel changed to 0 mid-packet -> ignored until last.
//     ext_sel=5 with N_IN=4 -> no grant.
//  6. Assert rst_n=0 while LOCKED with out_valid=1:
//     immediately out_valid=0, busy=0, in_ready=0.
//     After release, RR restarts at ch0.

Source files
------------

// File: rtl/stream_mux_arb_pkg.sv
// stream_pkg: shared arbitration modes and FSM state encoding for the stream mux
package stream_pkg;
   localparam int MODE_RR   = 0;
   localparam int MODE_PRIO = 1;
   localparam int MODE_EXT  = 2;
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after ptr with wrap
module rr_arbiter
   import stream_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic [N_IN-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_IN-1:0]  gnt,
   output logic [SEL_W-1:0] idx
);
   // scan N_IN slots starting at ptr; the first hit wins
   always_comb begin
      int j;
      gnt = '0;
      idx = '0;
      j = 0;
      for (int k = 0; k < N_IN; k++) begin
         j = 32'(ptr) + k;
         j = (j >= N_IN) ? j - N_IN : j;
         if (gnt == '0 && req[j]) begin
            gnt[j] = 1'b1;
            idx = SEL_W'(j);
         end
      end
   end
endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: N-to-1 registered stream mux with packet lock and selectable arbitration
module stream_mux_arb
   import stream_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_IN  = 4,
   parameter int MODE  = 0,
   parameter int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_IN*WIDTH-1:0] in_data,
   input  logic [N_IN-1:0]       in_valid,
   input  logic [N_IN-1:0]       in_last,
   output logic [N_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]      ext_sel,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   output logic                  out_last,
   output logic [SEL_W-1:0]      out_src,
   input  logic                  out_ready,
   output logic                  busy
);
   localparam logic [N_IN-1:0] lsb = N_IN'(1);
   state_t            state;
   logic [SEL_W-1:0]  rr_ptr, grant, g, arb_idx;
   logic [N_IN-1:0]   arb_gnt, sel_oh;
   logic              can_load, fire, last_g;
   rr_arbiter #(.N_IN(N_IN), .SEL_W(SEL_W)) u_arb (
      .req (in_valid),
      .ptr ((MODE == MODE_PRIO) ? '0 : rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );
   // channel selection: locked grant wins, otherwise the mode's arbitration result;
   // an out-of-range ext_sel shifts the one-hot away entirely, so it grants nothing
   always_comb begin
      can_load = !out_valid | out_ready;
      g        = (state == LOCKED) ? grant : (MODE == MODE_EXT) ? ext_sel : arb_idx;
      sel_oh   = (state == LOCKED) ? (lsb << grant)
               : (MODE == MODE_EXT) ? ((lsb << ext_sel) & in_valid) : arb_gnt;
      in_ready = (rst_n && can_load) ? sel_oh : '0;
      fire     = |(in_ready & in_valid);
      last_g   = |(sel_oh & in_last);
   end
   // output register, packet-lock FSM and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant     <= '0;
         rr_ptr    <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= '0;
      end else begin
         if (can_load) out_valid <= fire;
         if (fire) begin
            out_data <= WIDTH'(in_data >> (32'(g) * WIDTH));
            out_last <= last_g;
            out_src  <= g;
            state    <= last_g ? IDLE : LOCKED;
            busy     <= !last_g;
            grant    <= g;
            if (MODE == MODE_RR && last_g)
               rr_ptr <= (32'(g) == N_IN - 1) ? '0 : SEL_W'(32'(g) + 1);
         end
      end
   end
endmodule

// File: tb/tb_stream_mux_arb.sv
// tb_stream_mux_arb: directed checks of round-robin, priority and external-select muxes
module tb_stream_mux_arb;
   logic         clk, rst_n, out_ready;
   logic [127:0] in_data;
   logic [3:0]   in_valid, in_last;
   logic [1:0]   ext_zero;
   logic [2:0]   ext_sel;
   logic [3:0]   rr_in_ready, pr_in_ready, ex_in_ready;
   logic [31:0]  rr_data, pr_data, ex_data;
   logic         rr_valid, pr_valid, ex_valid, rr_last, pr_last, ex_last;
   logic         rr_busy, pr_busy, ex_busy;
   logic [1:0]   rr_src, pr_src;
   logic [2:0]   ex_src;
   int           checks = 0, errors = 0;
   stream_mux_arb #(.WIDTH(32), .N_IN(4), .MODE(0)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(rr_in_ready), .ext_sel(ext_zero), .out_data(rr_data), .out_valid(rr_valid),
      .out_last(rr_last), .out_src(rr_src), .out_ready(out_ready), .busy(rr_busy));
   stream_mux_arb #(.WIDTH(32), .N_IN(4), .MODE(1)) u_pr (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(pr_in_ready), .ext_sel(ext_zero), .out_data(pr_data), .out_valid(pr_valid),
      .out_last(pr_last), .out_src(pr_src), .out_ready(out_ready), .busy(pr_busy));
   stream_mux_arb #(.WIDTH(32), .N_IN(4), .MODE(2), .SEL_W(3)) u_ex (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(ex_in_ready), .ext_sel(ext_sel), .out_data(ex_data), .out_valid(ex_valid),
      .out_last(ex_last), .out_src(ex_src), .out_ready(out_ready), .busy(ex_busy));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic do_reset();
      in_valid = '0;
      in_last  = '0;
      rst_n    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic set_ch(input int i, input logic [31:0] v);
      in_data[i*32 +: 32] = v;
   endtask
   initial begin
      rst_n = 1'b0; out_ready = 1'b1; ext_zero = '0; ext_sel = '0;
      in_valid = 4'hF; in_last = 4'hF;
      for (int i = 0; i < 4; i++) set_ch(i, 32'h1000_0000 + 32'(i));
      #12;
      chk("reset out_valid", 32'(rr_valid), 32'd0);
      chk("reset out_data", rr_data, 32'd0);
      chk("reset busy", 32'(rr_busy), 32'd0);
      chk("reset in_ready", 32'(rr_in_ready), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rr first in_ready", 32'(rr_in_ready), 32'h1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rr single src", 32'(rr_src), 32'(k % 4));
         chk("rr single data", rr_data, 32'h1000_0000 + 32'(k % 4));
         chk("rr single valid", 32'(rr_valid), 32'd1);
      end
      do_reset();
      in_valid = 4'b0110; in_last = 4'b0100;
      set_ch(1, 32'h11); set_ch(2, 32'h22);
      #1;
      chk("pkt in_ready b1", 32'(rr_in_ready), 32'b0010);
      @(posedge clk); @(negedge clk);
      chk("pkt src b1", 32'(rr_src), 32'd1);
      chk("pkt data b1", rr_data, 32'h11);
      chk("pkt busy b1", 32'(rr_busy), 32'd1);
      chk("pkt in_ready locked", 32'(rr_in_ready), 32'b0010);
      set_ch(1, 32'h12);
      @(posedge clk); @(negedge clk);
      chk("pkt data b2", rr_data, 32'h12);
      chk("pkt in_ready b2", 32'(rr_in_ready), 32'b0010);
      set_ch(1, 32'h13); in_last = 4'b0110;
      @(posedge clk); @(negedge clk);
      chk("pkt data b3", rr_data, 32'h13);
      chk("pkt last b3", 32'(rr_last), 32'd1);
      chk("pkt busy end", 32'(rr_busy), 32'd0);
      in_valid = 4'b0100;
      #1;
      chk("pkt ch2 ready", 32'(rr_in_ready), 32'b0100);
      @(posedge clk); @(negedge clk);
      chk("pkt ch2 src", 32'(rr_src), 32'd2);
      chk("pkt ch2 data", rr_data, 32'h22);
      do_reset();
      in_valid = 4'b0001; in_last = 4'b0001; set_ch(0, 32'hA5A5_A5A5);
      @(posedge clk); @(negedge clk);
      chk("bp first data", rr_data, 32'hA5A5_A5A5);
      out_ready = 1'b0; set_ch(0, 32'h5A5A_5A5A);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp hold data", rr_data, 32'hA5A5_A5A5);
         chk("bp hold valid", 32'(rr_valid), 32'd1);
         chk("bp in_ready", 32'(rr_in_ready), 32'd0);
         @(posedge clk); @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("bp release ready", 32'(rr_in_ready), 32'b0001);
      @(posedge clk); @(negedge clk);
      chk("bp next data", rr_data, 32'h5A5A_5A5A);
      do_reset();
      in_valid = 4'b1001; in_last = 4'b1001;
      #1;
      chk("prio in_ready", 32'(pr_in_ready), 32'b0001);
      @(posedge clk); @(negedge clk);
      chk("prio src0 a", 32'(pr_src), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("prio src0 b", 32'(pr_src), 32'd0);
      in_valid = 4'b1000;
      @(posedge clk); @(negedge clk);
      chk("prio src3", 32'(pr_src), 32'd3);
      do_reset();
      in_valid = 4'b0101; in_last = 4'b0000; ext_sel = 3'd2;
      #1;
      chk("ext in_ready", 32'(ex_in_ready), 32'b0100);
      @(posedge clk); @(negedge clk);
      chk("ext src b1", 32'(ex_src), 32'd2);
      chk("ext busy", 32'(ex_busy), 32'd1);
      ext_sel = 3'd0;
      #1;
      chk("ext sel ignored", 32'(ex_in_ready), 32'b0100);
      @(posedge clk); @(negedge clk);
      chk("ext src b2", 32'(ex_src), 32'd2);
      in_last = 4'b0100;
      @(posedge clk); @(negedge clk);
      chk("ext src last", 32'(ex_src), 32'd2);
      chk("ext last", 32'(ex_last), 32'd1);
      chk("ext unlock", 32'(ex_busy), 32'd0);
      #1;
      chk("ext sel0 ready", 32'(ex_in_ready), 32'b0001);
      ext_sel = 3'd5; in_valid = 4'hF;
      #1;
      chk("ext sel5 ready", 32'(ex_in_ready), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("ext sel5 no beat", 32'(ex_valid), 32'd0);
      do_reset();
      in_valid = 4'b0010; in_last = 4'b0010;
      @(posedge clk); @(negedge clk);
      chk("rst pre src1", 32'(rr_src), 32'd1);
      in_valid = 4'b0100; in_last = 4'b0000;
      @(posedge clk); @(negedge clk);
      chk("rst locked src", 32'(rr_src), 32'd2);
      chk("rst locked busy", 32'(rr_busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst mid valid", 32'(rr_valid), 32'd0);
      chk("rst mid busy", 32'(rr_busy), 32'd0);
      chk("rst mid in_ready", 32'(rr_in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 4'hF; in_last = 4'hF;
      #1;
      chk("rst restart ready", 32'(rr_in_ready), 32'b0001);
      @(posedge clk); @(negedge clk);
      chk("rst restart src", 32'(rr_src), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
